// File: rtl/mul_unpack.sv
// Two-stage IEEE-754 operand unpacker: field split + classification (S1), exponent/significand forming (S2).
// Define MUL_UNPACK_SUBNORM_EN to normalise subnormals in S2; otherwise they are flushed to zero (DAZ).
module mul_unpack #(
  parameter int SIGN_W = 1,
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [SIGN_W+EXPO_W+MANT_W-1:0]   in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_sign,
  output logic [EXPO_W:0]                   out_expo,
  output logic [MANT_W:0]                   out_mant,
  output logic                              out_zero,
  output logic                              out_subn,
  output logic                              out_inf,
  output logic                              out_nan,
  output logic                              out_snan
);

  localparam int DATA_W = SIGN_W + EXPO_W + MANT_W;

  // Class vector bit order: {zero, subn, inf, nan, snan}
  logic              s1_valid_q, s1_valid_d;
  logic              s1_sign_q, s1_sign_d;
  logic [EXPO_W-1:0] s1_expo_q, s1_expo_d;
  logic [MANT_W-1:0] s1_mant_q, s1_mant_d;
  logic [4:0]        s1_cls_q, s1_cls_d;

  logic              s2_valid_q, s2_valid_d;
  logic              s2_sign_q, s2_sign_d;
  logic [EXPO_W:0]   s2_expo_q, s2_expo_d;
  logic [MANT_W:0]   s2_mant_q, s2_mant_d;
  logic [4:0]        s2_cls_q, s2_cls_d;

  logic              s2_ready, s1_load, s1_move;
  logic              in_sign;
  logic [EXPO_W-1:0] in_expo;
  logic [MANT_W-1:0] in_mant;
  logic              e_zero, e_ones, m_zero;

`ifdef MUL_UNPACK_SUBNORM_EN
  localparam int LZ_W = $clog2(MANT_W + 1);
  logic [LZ_W-1:0] lz;

  function automatic logic [LZ_W-1:0] lzc(input logic [MANT_W-1:0] m);
    lzc = '0;
    for (int i = 0; i < MANT_W; i++) begin
      if (m[i]) lzc = LZ_W'(MANT_W - 1 - i);
    end
  endfunction

  assign lz = lzc(s1_mant_q);
`endif

  assign in_sign  = in_data[DATA_W-1];
  assign in_expo  = in_data[MANT_W +: EXPO_W];
  assign in_mant  = in_data[MANT_W-1:0];
  assign e_zero   = (in_expo == '0);
  assign e_ones   = &in_expo;
  assign m_zero   = (in_mant == '0);

  assign s2_ready = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_ready;
  assign s1_load  = in_valid && in_ready;
  assign s1_move  = s1_valid_q && s2_ready;

  always_comb begin
    s1_valid_d = s1_load || (s1_valid_q && !s2_ready);
    s1_sign_d  = s1_sign_q;
    s1_expo_d  = s1_expo_q;
    s1_mant_d  = s1_mant_q;
    s1_cls_d   = s1_cls_q;
    if (s1_load) begin
      s1_sign_d = in_sign;
      s1_expo_d = in_expo;
      s1_mant_d = in_mant;
`ifdef MUL_UNPACK_SUBNORM_EN
      s1_cls_d[4] = e_zero && m_zero;
`else
      s1_cls_d[4] = e_zero;
`endif
      s1_cls_d[3] = e_zero && !m_zero;
      s1_cls_d[2] = e_ones && m_zero;
      s1_cls_d[1] = e_ones && !m_zero;
      s1_cls_d[0] = e_ones && !m_zero && !in_mant[MANT_W-1];
    end
  end

  always_comb begin
    s2_valid_d = s2_ready ? s1_valid_q : s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_expo_d  = s2_expo_q;
    s2_mant_d  = s2_mant_q;
    s2_cls_d   = s2_cls_q;
    if (s1_move) begin
      s2_sign_d = s1_sign_q;
      s2_cls_d  = s1_cls_q;
      if (s1_cls_q[4]) begin
        // Covers true zeros and, in DAZ builds, flushed subnormals
        s2_expo_d = '0;
        s2_mant_d = '0;
`ifdef MUL_UNPACK_SUBNORM_EN
      end else if (s1_cls_q[3]) begin
        s2_expo_d = -((EXPO_W + 1)'(lz));
        s2_mant_d = ({1'b0, s1_mant_q} << lz) << 1;
`endif
      end else if (s1_cls_q[2] || s1_cls_q[1]) begin
        s2_expo_d = {1'b0, s1_expo_q};
        s2_mant_d = {1'b0, s1_mant_q};
      end else begin
        s2_expo_d = {1'b0, s1_expo_q};
        s2_mant_d = {1'b1, s1_mant_q};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_expo_q  <= '0;
      s1_mant_q  <= '0;
      s1_cls_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_expo_q  <= '0;
      s2_mant_q  <= '0;
      s2_cls_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_expo_q  <= s1_expo_d;
      s1_mant_q  <= s1_mant_d;
      s1_cls_q   <= s1_cls_d;
      s2_valid_q <= s2_valid_d;
      s2_sign_q  <= s2_sign_d;
      s2_expo_q  <= s2_expo_d;
      s2_mant_q  <= s2_mant_d;
      s2_cls_q   <= s2_cls_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_sign  = s2_sign_q;
  assign out_expo  = s2_expo_q;
  assign out_mant  = s2_mant_q;
  assign out_zero  = s2_cls_q[4];
  assign out_subn  = s2_cls_q[3];
  assign out_inf   = s2_cls_q[2];
  assign out_nan   = s2_cls_q[1];
  assign out_snan  = s2_cls_q[0];

endmodule

// File: tb/tb_mul_unpack.sv
// Bench for mul_unpack (single precision); reference model follows MUL_UNPACK_SUBNORM_EN like the DUT.
module tb_mul_unpack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data;
  logic        out_sign, out_zero, out_subn, out_inf, out_nan, out_snan;
  logic [8:0]  out_expo;
  logic [23:0] out_mant;
  logic [38:0] dut_vec;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul_unpack #(.SIGN_W(1), .EXPO_W(8), .MANT_W(23)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_expo(out_expo), .out_mant(out_mant),
    .out_zero(out_zero), .out_subn(out_subn), .out_inf(out_inf),
    .out_nan(out_nan), .out_snan(out_snan)
  );

  assign dut_vec = {out_sign, out_expo, out_mant, out_zero, out_subn, out_inf, out_nan, out_snan};

  // Reference: {sign, expo[8:0], mant[23:0], zero, subn, inf, nan, snan}
  function automatic logic [38:0] ref_unpack(input logic [31:0] d);
    logic s;
    int e, m;
    logic [8:0]  xe;
    logic [23:0] xm;
    logic [4:0]  f;
    s = d[31]; e = int'(d[30:23]); m = int'(d[22:0]);
    xe = '0; xm = '0; f = '0;
    if (e == 0 && m == 0) begin
      f = 5'b10000;
    end else if (e == 0) begin
`ifdef MUL_UNPACK_SUBNORM_EN
      int k;
      k = 0;
      while (m < (1 << 23)) begin
        m = m * 2;
        k++;
      end
      xe = 9'(1 - k);
      xm = 24'(m);
      f  = 5'b01000;
`else
      f  = 5'b11000;
`endif
    end else if (e == 255) begin
      xe = 9'(e);
      xm = 24'(m);
      if (m == 0)              f = 5'b00100;
      else if (m >= (1 << 22)) f = 5'b00010;
      else                     f = 5'b00011;
    end else begin
      xe = 9'(e);
      xm = 24'(m + (1 << 23));
    end
    return {s, xe, xm, f};
  endfunction

  function automatic logic [31:0] rand_op();
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    int sel;
    s = 1'($urandom);
    e = 8'($urandom);
    m = 23'($urandom) >> $urandom_range(0, 22);
    sel = $urandom_range(0, 5);
    case (sel)
      0: begin e = 8'h00; m = '0; end
      1: e = 8'h00;
      2: begin e = 8'hFF; m = '0; end
      3: e = 8'hFF;
      default: ;
    endcase
    return {s, e, m};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (dut_vec !== 39'h0) begin failures++; $display("FAIL reset_fields got=%h exp=0", dut_vec); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready_held got=%b exp=1", in_ready); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready_rel got=%b exp=1", in_ready); end
  endtask

  task automatic test_single(input string name, input logic [31:0] op, input logic [38:0] exp);
    @(negedge clk); in_valid = 1'b1; in_data = op; out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL %s_in_ready got=%b exp=1", name, in_ready); end
    @(negedge clk); in_valid = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL %s_early got=%b exp=0", name, out_valid); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL %s_valid got=%b exp=1", name, out_valid); end
    checks++; if (dut_vec !== exp) begin failures++; $display("FAIL %s_fields got=%h exp=%h", name, dut_vec, exp); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL %s_dup got=%b exp=0", name, out_valid); end
  endtask

  task automatic test_normal();
    test_single("normal", 32'h3FC00000, {1'b0, 9'd127, 24'hC00000, 5'b00000});
  endtask

  task automatic test_subnormal();
`ifdef MUL_UNPACK_SUBNORM_EN
    test_single("subnormal", 32'h00000001, {1'b0, 9'h1EA, 24'h800000, 5'b01000});
`else
    test_single("subnormal", 32'h00000001, {1'b0, 9'h000, 24'h000000, 5'b11000});
`endif
  endtask

  task automatic test_specials();
    logic [31:0] ops [4];
    logic [38:0] exps [4];
    ops[0] = 32'h80000000; exps[0] = {1'b1, 9'h000, 24'h000000, 5'b10000};
    ops[1] = 32'h7F800000; exps[1] = {1'b0, 9'h0FF, 24'h000000, 5'b00100};
    ops[2] = 32'h7FC00000; exps[2] = {1'b0, 9'h0FF, 24'h400000, 5'b00010};
    ops[3] = 32'h7F800001; exps[3] = {1'b0, 9'h0FF, 24'h000001, 5'b00011};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = (i < 4);
      if (i < 4) in_data = ops[i];
      #1;
      if (i >= 2) begin
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL specials_valid[%0d] got=%b exp=1", i - 2, out_valid); end
        checks++; if (dut_vec !== exps[i-2]) begin failures++; $display("FAIL specials_fields[%0d] got=%h exp=%h", i - 2, dut_vec, exps[i-2]); end
      end
    end
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] ops [3];
    logic [8:0]  exps [3];
    ops[0] = 32'h3F800000; ops[1] = 32'h40000000; ops[2] = 32'h40400000;
    exps[0] = 9'd127; exps[1] = 9'd128; exps[2] = 9'd128;
    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_data = ops[0]; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_accept0 got=%b exp=1", in_ready); end
    @(negedge clk); in_data = ops[1]; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_accept1 got=%b exp=1", in_ready); end
    @(negedge clk); in_data = ops[2];
    for (int c = 0; c < 2; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full[%0d] got=%b exp=0", c, in_ready); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%b exp=1", c, out_valid); end
      checks++; if (dut_vec !== ref_unpack(ops[0])) begin failures++; $display("FAIL bp_hold[%0d] got=%h exp=%h", c, dut_vec, ref_unpack(ops[0])); end
    end
    @(negedge clk); out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%b exp=1", in_ready); end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        @(negedge clk); in_valid = 1'b0; #1;
      end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid[%0d] got=%b exp=1", k, out_valid); end
      checks++; if (out_expo !== exps[k]) begin failures++; $display("FAIL bp_expo[%0d] got=%0d exp=%0d", k, out_expo, exps[k]); end
      checks++; if (dut_vec !== ref_unpack(ops[k])) begin failures++; $display("FAIL bp_fields[%0d] got=%h exp=%h", k, dut_vec, ref_unpack(ops[k])); end
    end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_data = 32'h41200000;
    @(negedge clk); in_data = 32'hC1A00000;
    @(negedge clk); in_valid = 1'b0; #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rstmid_loaded got=%b exp=1", out_valid); end
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
    checks++; if (dut_vec !== 39'h0) begin failures++; $display("FAIL rstmid_fields got=%h exp=0", dut_vec); end
    @(negedge clk); rst = 1'b0; out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_stale[%0d] got=%b exp=0", c, out_valid); end
    end
  endtask

  task automatic test_random();
    logic [38:0] exp_q[$];
    logic [38:0] e, prev_vec;
    logic        prev_stall;
    int          n_in, n_out;
    n_in = 0; n_out = 0; prev_stall = 1'b0; prev_vec = '0;
    for (int c = 0; c < 10050; c++) begin
      @(negedge clk);
      in_valid  = (c < 10000) && ($urandom_range(0, 3) != 0);
      in_data   = rand_op();
      out_ready = (c >= 10000) || ($urandom_range(0, 3) != 0);
      #1;
      if (prev_stall) begin
        checks++; if (dut_vec !== prev_vec || out_valid !== 1'b1) begin failures++; $display("FAIL rand_stall_hold cycle=%0d got=%h exp=%h", c, dut_vec, prev_vec); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rand_extra_output cycle=%0d got=%h exp=none", c, dut_vec);
        end else begin
          e = exp_q.pop_front();
          n_out++;
          if (dut_vec !== e) begin failures++; $display("FAIL rand_fields cycle=%0d got=%h exp=%h", c, dut_vec, e); end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_unpack(in_data));
        n_in++;
      end
      prev_stall = out_valid && !out_ready;
      prev_vec   = dut_vec;
    end
    in_valid = 1'b0;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rand_dropped got=%0d exp=0", exp_q.size()); end
    checks++; if (n_out != n_in || n_in < 5000) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", n_out, n_in); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    test_reset();
    test_normal();
    test_specials();
    test_subnormal();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
